// File: rtl/sand_scene_mem.sv
// Falling-sand scene buffer: one byte per cell behind an Avalon-MM slave, plus a
// higher-priority scanout read port. Clears the whole grid after every reset.
module sand_scene_mem #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] writedata,
  input  logic              disp_req,
  input  logic [14:0]       disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic [7:0]        oob_count,
  output logic              proto_err
);
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int RAM_AW = $clog2(CELLS);

  typedef enum logic [1:0] {CLEAR, IDLE, RD_DATA} state_t;

  typedef struct packed {
    logic              we;
    logic [RAM_AW-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  state_t            state;
  logic [RAM_AW-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [CELLS];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rd_hold;
  logic              rd_oob;
  logic              disp_hit;
  ram_req_t          req;

  logic av_oob, disp_oob, av_rd_go, av_wr_go, oob_inc;

  assign av_oob   = address >= ADDR_W'(CELLS);
  assign disp_oob = disp_addr >= 15'(CELLS);
  // A simultaneous read+write is served as a read; the write half is dropped.
  assign av_rd_go = (state == IDLE) && read && !disp_req;
  assign av_wr_go = (state == IDLE) && write && !read && !disp_req;
  assign oob_inc  = (av_rd_go || av_wr_go) && av_oob;

  assign waitrequest = reset || !((state == RD_DATA) || av_wr_go);
  assign readdata    = (state == RD_DATA) ? (rd_oob ? '0 : ram_q) : rd_hold;
  assign disp_data   = disp_hit ? ram_q : '0;

  always_comb begin
    req = '0;
    if (state == CLEAR) begin
      req.we   = 1'b1;
      req.addr = clr_cnt;
    end else if (disp_req) begin
      req.addr = disp_oob ? '0 : RAM_AW'(disp_addr);
    end else if (av_rd_go) begin
      req.addr = av_oob ? '0 : address[RAM_AW-1:0];
    end else if (av_wr_go && !av_oob) begin
      req.we    = 1'b1;
      req.addr  = address[RAM_AW-1:0];
      req.wdata = writedata;
    end
  end

  always_ff @(posedge clock) begin
    if (req.we) mem[req.addr] <= req.wdata;
    ram_q <= mem[req.addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      rd_hold    <= '0;
      rd_oob     <= 1'b0;
      disp_valid <= 1'b0;
      disp_hit   <= 1'b0;
      oob_count  <= '0;
      proto_err  <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      disp_hit   <= disp_req && (state != CLEAR) && !disp_oob;
      if (read && write) proto_err <= 1'b1;
      if (oob_inc && oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == RAM_AW'(CELLS - 1)) state <= IDLE;
        end
        IDLE: begin
          if (av_rd_go) begin
            state  <= RD_DATA;
            rd_oob <= av_oob;
          end
        end
        RD_DATA: begin
          // ram_q may be overwritten by a scanout read issued this cycle.
          rd_hold <= readdata;
          state   <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_sand_scene_mem.sv
// Directed bench for sand_scene_mem: clear sweep, read/write timing, scanout
// priority, out-of-range handling, protocol error and mid-read reset.
module tb_sand_scene_mem;
  logic        clock, reset;
  logic [22:0] address;
  logic        read, write, waitrequest;
  logic [7:0]  readdata, writedata, disp_data, oob_count;
  logic        disp_req, disp_valid, proto_err;
  logic [14:0] disp_addr;

  int total = 0;
  int bad   = 0;

  sand_scene_mem dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .readdata(readdata), .writedata(writedata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .oob_count(oob_count), .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic av_wr(input logic [22:0] a, input logic [7:0] d, output int st);
    address = a; writedata = d; write = 1'b1; read = 1'b0; st = 0;
    #1;
    while (waitrequest && st < 50) begin
      st++;
      next();
      #1;
    end
    next();
    write = 1'b0;
  endtask

  task automatic av_rd(input logic [22:0] a, input logic both, output logic [7:0] d, output int st);
    address = a; read = 1'b1; write = both; writedata = 8'h55; st = 0;
    #1;
    while (waitrequest && st < 50) begin
      st++;
      next();
      #1;
    end
    d = readdata;
    next();
    read = 1'b0;
    write = 1'b0;
  endtask

  // Counts further cycles with waitrequest high; inputs stay as the caller set them.
  task automatic wait_ready(output int n);
    n = 0;
    while (waitrequest && n < 25000) begin
      n++;
      next();
      #1;
    end
  endtask

  initial begin
    logic [7:0] d;
    int st, n;
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    disp_req = 1'b0; disp_addr = '0;
    repeat (2) next();

    // CLEAR cycle 0: reset values, then count the sweep with a write held.
    reset = 1'b0;
    address = 23'd5; writedata = 8'h00; write = 1'b1;
    #1;
    chk("rst_wait", waitrequest, 1);
    chk("rst_rdata", readdata, 0);
    chk("rst_dvalid", disp_valid, 0);
    chk("rst_ddata", disp_data, 0);
    chk("rst_oob", oob_count, 0);
    chk("rst_perr", proto_err, 0);
    wait_ready(n);
    chk("clear_len", n, 19200);
    next();
    write = 1'b0;

    av_rd(23'd0, 1'b0, d, st);     chk("clr0_st", st, 1);   chk("clr0", d, 0);
    av_rd(23'd9600, 1'b0, d, st);  chk("clr9600", d, 0);
    av_rd(23'd19199, 1'b0, d, st); chk("clr19199", d, 0);

    // Write then immediate read-back.
    av_wr(23'd321, 8'h02, st);     chk("wr321_st", st, 0);
    address = 23'd321; read = 1'b1;
    #1; chk("rd321_w1", waitrequest, 1);
    next();
    #1; chk("rd321_w0", waitrequest, 0); chk("rd321", readdata, 8'h02);
    next(); read = 1'b0;
    #1; chk("rd_hold", readdata, 8'h02);

    // Scanout holds off a pending write for three cycles.
    disp_req = 1'b1; disp_addr = 15'd321; address = 23'd5; writedata = 8'h01; write = 1'b1;
    #1; chk("dsp_w0", waitrequest, 1); chk("dsp_v0", disp_valid, 0);
    next(); disp_addr = 15'd5;
    #1; chk("dsp_w1", waitrequest, 1); chk("dsp_v1", disp_valid, 1); chk("dsp_d321", disp_data, 8'h02);
    next(); disp_addr = 15'd19200;
    #1; chk("dsp_w2", waitrequest, 1); chk("dsp_v2", disp_valid, 1); chk("dsp_d5", disp_data, 8'h00);
    next(); disp_req = 1'b0;
    #1; chk("dsp_w3", waitrequest, 0); chk("dsp_v3", disp_valid, 1); chk("dsp_doob", disp_data, 8'h00);
    next(); write = 1'b0;
    #1; chk("dsp_v4", disp_valid, 0);
    av_rd(23'd5, 1'b0, d, st);     chk("rd5", d, 8'h01);

    // Out-of-range accesses and saturation.
    av_wr(23'd19200, 8'hAA, st);   chk("oobwr_st", st, 0);
    #1; chk("oob1", oob_count, 1);
    av_rd(23'h7FFFFF, 1'b0, d, st); chk("oobrd_st", st, 1); chk("oobrd", d, 0);
    #1; chk("oob2", oob_count, 2);
    for (int i = 0; i < 300; i++) av_wr(23'd20000 + 23'(i), 8'hAA, st);
    #1; chk("oob_sat", oob_count, 255);
    av_rd(23'd0, 1'b0, d, st);     chk("oob_nowrite", d, 0);

    // Read and write together.
    av_wr(23'd7, 8'h03, st);
    #1; chk("perr_pre", proto_err, 0);
    av_rd(23'd7, 1'b1, d, st);     chk("rw_st", st, 1);     chk("rw_data", d, 8'h03);
    #1; chk("perr_set", proto_err, 1);
    av_rd(23'd7, 1'b0, d, st);     chk("rw_cell", d, 8'h03);
    #1; chk("perr_sticky", proto_err, 1);

    // Reset during RD_DATA.
    address = 23'd7; read = 1'b1;
    #1; chk("mrst_w", waitrequest, 1);
    next(); reset = 1'b1; disp_req = 1'b1; disp_addr = 15'd321; read = 1'b0;
    next(); reset = 1'b0; address = 23'd9; writedata = 8'h00; write = 1'b1;
    #1;
    chk("mrst_dvalid", disp_valid, 0);
    chk("mrst_wait", waitrequest, 1);
    chk("mrst_perr", proto_err, 0);
    chk("mrst_oob", oob_count, 0);
    chk("mrst_rdata", readdata, 0);
    next(); disp_req = 1'b0;
    #1; chk("clr_dvalid", disp_valid, 1); chk("clr_ddata", disp_data, 0);
    wait_ready(n);
    chk("reclear_len", n + 1, 19200);
    next(); write = 1'b0;
    av_rd(23'd7, 1'b0, d, st);     chk("reclr7", d, 0);
    av_rd(23'd321, 1'b0, d, st);   chk("reclr321", d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sand_scene_mem.md
# sand_scene_mem

Avalon-MM slave that owns the on-chip falling-sand scene buffer: one byte per cell, linear address y*GRID_W + x. It answers the read/write/waitrequest master port driven by the sand update engine and gives the VGA scanout a second, higher-priority read port. After every reset it clears the whole grid to 0 (empty cells) before it accepts traffic.

## Interface
Parameters:
- GRID_W, 160: cells per row
- GRID_H, 120: rows
- ADDR_W, 23: Avalon address width, in bytes
- DATA_W, 8: cell width

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- address  in  ADDR_W  Avalon byte address
- read  in  1  Avalon read request
- write  in  1  Avalon write request
- waitrequest  out  1  Avalon stall (combinational from state and inputs)
- readdata  out  DATA_W  Avalon read data
- writedata  in  DATA_W  Avalon write data
- disp_req  in  1  scanout read request
- disp_addr  in  15  scanout cell address
- disp_data  out  DATA_W  scanout read data
- disp_valid  out  1  disp_data valid
- oob_count  out  8  saturating count of out-of-range accesses
- proto_err  out  1  sticky: read and write asserted together

## Operation
- Storage: single-port synchronous RAM of GRID_W*GRID_H (19200) bytes with 1-cycle read latency. One access per cycle.
- Access priority, highest first: CLEAR sweep, then disp_req, then the Avalon port.
- FSM states:
  - CLEAR: entered on reset. A 15-bit counter writes 0 to addresses 0..19199, one per cycle. Move to IDLE after address 19199 is written. waitrequest=1 throughout.
  - IDLE:
    - read=1 and the RAM is free: issue the RAM read, waitrequest=1, go to RD_DATA.
    - write=1 and the RAM is free: commit the write, waitrequest=0. The transfer ends this cycle.
    - RAM taken by disp_req: waitrequest=1, stay in IDLE. The master holds its request and retries.
  - RD_DATA: readdata carries the RAM output, waitrequest=0, go to IDLE. A disp_req in this cycle is serviced; it does not disturb readdata, which is held in a register.
- read and write both =1: treat as a read, drop the write, set proto_err (sticky until reset).
- Out-of-range address (address >= GRID_W*GRID_H, compared at full ADDR_W):
  - Write: accepted with waitrequest=0, dropped, oob_count+1.
  - Read: same 2-cycle shape, readdata=0, oob_count+1.
  - oob_count saturates at 255.
- disp_addr >= 19200: disp_data=0, disp_valid still pulses.
- disp_req during CLEAR: disp_valid pulses and disp_data=0. No RAM access is made.
- readdata holds its last value between reads.

## Timing
- Reset values: waitrequest=1, readdata=0, disp_data=0, disp_valid=0, oob_count=0, proto_err=0, FSM=CLEAR, clear counter=0.
- Reset is sampled every cycle. Reset mid-read or mid-clear discards the transfer and restarts CLEAR from address 0.
- CLEAR lasts 19200 cycles after reset deasserts. The first Avalon transfer can be accepted in cycle 19200.
- Read latency: request in cycle N with RAM free; waitrequest=1 in N, data and waitrequest=0 in N+1.
- Write latency: completes in the request cycle when the RAM is free.
- Each disp_req cycle adds one stall cycle to a pending Avalon request in IDLE.
- Scanout: disp_req in cycle N gives disp_valid=1 and disp_data in N+1. Back-to-back requests give one result per cycle.
- A write in cycle N followed by a read of the same address starting in N+1 returns the new value.

## Test plan
- Reset, idle master; sample readdata from cells 0, 9600 and 19199 after CLEAR -> waitrequest=1 for exactly 19200 cycles; all three reads return 0x00.
- Write 0x02 to address 321, then read address 321 -> write waitrequest=0 in the same cycle; read shows waitrequest 1 then 0; readdata=0x02 on the second cycle.
- Hold disp_req=1 for 3 cycles while the master writes 0x01 to address 5 -> waitrequest=1 for 3 cycles, write commits on cycle 4; disp_valid=1 for 3 cycles.
- Write 0xAA to address 19200; read address 0x7FFFFF; then issue 300 more out-of-range writes -> write dropped, read returns 0x00, oob_count steps 1, 2, then saturates at 255.
- Assert read=1 and write=1 together at address 7 (cell value 0x03) -> read returns 0x03, cell unchanged, proto_err=1 until the next reset.
- Assert reset for 1 cycle during an RD_DATA cycle -> disp_valid=0 and waitrequest=1 next cycle, CLEAR restarts from address 0, proto_err and oob_count return to 0.
